// File: rtl/mesh_seq_ctrl.sv
// Global sequencer for the tile_pe mesh: weight broadcast, then n_iter rounds of LOAD_X + MAC.
module mesh_seq_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned ROW_W = 4,
    parameter int unsigned COL_W = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   load_w,
    input  logic [LEN_W-1:0]       cfg_x_len,
    input  logic [LEN_W-1:0]       cfg_mac_len,
    input  logic [LEN_W-1:0]       cfg_n_iter,
    input  logic [DW-1:0]          w_data,
    input  logic                   w_valid,
    output logic                   w_ready,
    output logic [ROW_W+COL_W-1:0] cfg_addr,
    output logic [DW-1:0]          cfg_data,
    output logic                   cfg_valid,
    output logic [1:0]             global_state,
    output logic                   x_phase,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned AW = ROW_W + COL_W;

    localparam logic [1:0] GS_LOAD_W = 2'd0;
    localparam logic [1:0] GS_LOAD_X = 2'd1;
    localparam logic [1:0] GS_MAC    = 2'd2;
    localparam logic [1:0] GS_IDLE   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WLOAD  = 3'd1,
        S_WFLUSH = 3'd2,
        S_XLOAD  = 3'd3,
        S_MAC    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LEN_W-1:0] x_len_q;
    logic [LEN_W-1:0] mac_len_q;
    logic [LEN_W-1:0] n_iter_q;
    logic [LEN_W-1:0] phase_cnt;
    logic [LEN_W-1:0] round_cnt;
    logic [AW-1:0]    tile_cnt;

    logic hs;
    logic tile_last;
    logic x_last;
    logic mac_last;
    logic round_last;

    logic [1:0] gs_nxt;
    logic       busy_nxt;
    logic       x_phase_nxt;
    logic       w_ready_nxt;
    logic       done_nxt;
    logic       cfg_valid_nxt;

    // Weight handshake and phase-end decodes
    assign hs         = (state == S_WLOAD) && w_valid && w_ready;
    assign tile_last  = &tile_cnt;
    assign x_last     = (phase_cnt == (x_len_q - LEN_W'(1)));
    assign mac_last   = (phase_cnt == (mac_len_q - LEN_W'(1)));
    assign round_last = (round_cnt == (n_iter_q - LEN_W'(1)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (load_w) begin
                        state_nxt = S_WLOAD;
                    end else if (cfg_n_iter == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_XLOAD;
                    end
                end
            end
            S_WLOAD: begin
                if (hs && tile_last) begin
                    state_nxt = S_WFLUSH;
                end
            end
            S_WFLUSH: begin
                state_nxt = (n_iter_q == '0) ? S_DONE : S_XLOAD;
            end
            S_XLOAD: begin
                if (x_last) begin
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (mac_last) begin
                    state_nxt = round_last ? S_DONE : S_XLOAD;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the state being entered, so outputs switch on the entry edge
    always_comb begin
        gs_nxt        = GS_IDLE;
        busy_nxt      = 1'b0;
        x_phase_nxt   = 1'b0;
        w_ready_nxt   = 1'b0;
        done_nxt      = 1'b0;
        cfg_valid_nxt = hs;
        case (state_nxt)
            S_WLOAD: begin
                gs_nxt      = GS_LOAD_W;
                busy_nxt    = 1'b1;
                w_ready_nxt = 1'b1;
            end
            S_WFLUSH: begin
                gs_nxt   = GS_LOAD_W;
                busy_nxt = 1'b1;
            end
            S_XLOAD: begin
                gs_nxt      = GS_LOAD_X;
                busy_nxt    = 1'b1;
                x_phase_nxt = 1'b1;
            end
            S_MAC: begin
                gs_nxt   = GS_MAC;
                busy_nxt = 1'b1;
            end
            S_DONE: begin
                done_nxt = 1'b1;
            end
            default: begin
                gs_nxt = GS_IDLE;
            end
        endcase
    end

    // Registered outputs; the broadcast word is captured on each accepted weight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            global_state <= GS_IDLE;
            busy         <= 1'b0;
            x_phase      <= 1'b0;
            w_ready      <= 1'b0;
            done         <= 1'b0;
            cfg_valid    <= 1'b0;
            cfg_addr     <= '0;
            cfg_data     <= '0;
        end else begin
            global_state <= gs_nxt;
            busy         <= busy_nxt;
            x_phase      <= x_phase_nxt;
            w_ready      <= w_ready_nxt;
            done         <= done_nxt;
            cfg_valid    <= cfg_valid_nxt;
            if (hs) begin
                cfg_addr <= tile_cnt;
                cfg_data <= w_data;
            end
        end
    end

    // Job configuration latched at start; zero phase lengths clamp to one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_len_q   <= LEN_W'(1);
            mac_len_q <= LEN_W'(1);
            n_iter_q  <= '0;
        end else if (state == S_IDLE && start) begin
            x_len_q   <= (cfg_x_len == '0) ? LEN_W'(1) : cfg_x_len;
            mac_len_q <= (cfg_mac_len == '0) ? LEN_W'(1) : cfg_mac_len;
            n_iter_q  <= cfg_n_iter;
        end
    end

    // Cycles spent in the current LOAD_X or MAC phase; cleared on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if ((state == S_XLOAD || state == S_MAC) && state_nxt == state) begin
            phase_cnt <= phase_cnt + LEN_W'(1);
        end else begin
            phase_cnt <= '0;
        end
    end

    // Completed LOAD_X+MAC rounds in this job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_cnt <= '0;
        end else if (state == S_IDLE) begin
            round_cnt <= '0;
        end else if (state == S_MAC && mac_last) begin
            round_cnt <= round_cnt + LEN_W'(1);
        end
    end

    // Row-major tile address for the next weight; wraps to zero after the last tile
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_cnt <= '0;
        end else if (state == S_IDLE) begin
            tile_cnt <= '0;
        end else if (hs) begin
            tile_cnt <= tile_cnt + AW'(1);
        end
    end

endmodule

// File: tb/tb_mesh_seq_ctrl.sv
// Directed self-checking bench for mesh_seq_ctrl on a 2x2 mesh.
module tb_mesh_seq_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned ROW_W = 1;
    localparam int unsigned COL_W = 1;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned AW    = ROW_W + COL_W;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             load_w;
    logic [LEN_W-1:0] cfg_x_len;
    logic [LEN_W-1:0] cfg_mac_len;
    logic [LEN_W-1:0] cfg_n_iter;
    logic [DW-1:0]    w_data;
    logic             w_valid;
    logic             w_ready;
    logic [AW-1:0]    cfg_addr;
    logic [DW-1:0]    cfg_data;
    logic             cfg_valid;
    logic [1:0]       global_state;
    logic             x_phase;
    logic             busy;
    logic             done;

    int total;
    int bad;

    mesh_seq_ctrl #(
        .DW    (DW),
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .load_w       (load_w),
        .cfg_x_len    (cfg_x_len),
        .cfg_mac_len  (cfg_mac_len),
        .cfg_n_iter   (cfg_n_iter),
        .w_data       (w_data),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .global_state (global_state),
        .x_phase      (x_phase),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".gs"},    32'(global_state), 32'd3);
        check({tag, ".addr"},  32'(cfg_addr),     32'd0);
        check({tag, ".data"},  32'(cfg_data),     32'd0);
        check({tag, ".cval"},  32'(cfg_valid),    32'd0);
        check({tag, ".wrdy"},  32'(w_ready),      32'd0);
        check({tag, ".xph"},   32'(x_phase),      32'd0);
        check({tag, ".busy"},  32'(busy),         32'd0);
        check({tag, ".done"},  32'(done),         32'd0);
    endtask

    task automatic kick(input logic lw, input int xl, input int ml, input int ni);
        start       = 1'b1;
        load_w      = lw;
        cfg_x_len   = LEN_W'(xl);
        cfg_mac_len = LEN_W'(ml);
        cfg_n_iter  = LEN_W'(ni);
        step();
        start       = 1'b0;
    endtask

    logic [DW-1:0] wv [4] = '{8'd11, 8'd22, 8'd33, 8'd44};
    int exp_gs   [12] = '{1, 1, 2, 2, 2, 1, 1, 2, 2, 2, 3, 3};
    int exp_done [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int exp_busy [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};

    initial begin
        int k;
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        load_w      = 1'b0;
        cfg_x_len   = '0;
        cfg_mac_len = '0;
        cfg_n_iter  = '0;
        w_data      = '0;
        w_valid     = 1'b0;

        // Reset values
        step();
        step();
        check_reset_vals("rst");
        rst_n = 1'b1;
        step();
        check_reset_vals("idle");

        // Back-to-back weights 11..44, then one short round
        kick(1'b1, 1, 1, 1);
        check("t1.entry.gs",   32'(global_state), 32'd0);
        check("t1.entry.wrdy", 32'(w_ready),      32'd1);
        check("t1.entry.cval", 32'(cfg_valid),    32'd0);
        check("t1.entry.busy", 32'(busy),         32'd1);
        w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_data = wv[i];
            step();
            check($sformatf("t1.w%0d.cval", i), 32'(cfg_valid),    32'd1);
            check($sformatf("t1.w%0d.addr", i), 32'(cfg_addr),     32'(i));
            check($sformatf("t1.w%0d.data", i), 32'(cfg_data),     32'(wv[i]));
            check($sformatf("t1.w%0d.gs", i),   32'(global_state), 32'd0);
        end
        check("t1.flush.wrdy", 32'(w_ready), 32'd0);
        w_valid = 1'b0;
        step();
        check("t1.x.gs",   32'(global_state), 32'd1);
        check("t1.x.xph",  32'(x_phase),      32'd1);
        check("t1.x.cval", 32'(cfg_valid),    32'd0);
        step();
        check("t1.mac.gs",  32'(global_state), 32'd2);
        check("t1.mac.xph", 32'(x_phase),      32'd0);
        step();
        check("t1.done.gs",   32'(global_state), 32'd3);
        check("t1.done.done", 32'(done),         32'd1);
        check("t1.done.busy", 32'(busy),         32'd0);
        step();
        check("t1.idle.done", 32'(done), 32'd0);

        // Gapped weight stream, n_iter=0 so the flush exits straight to DONE
        kick(1'b1, 1, 1, 0);
        k = 0;
        for (int c = 0; c < 7; c++) begin
            w_valid = ((c % 2) == 0);
            w_data  = DW'(100 + c);
            step();
            check($sformatf("t2.c%0d.cval", c), 32'(cfg_valid),    32'(w_valid));
            check($sformatf("t2.c%0d.gs", c),   32'(global_state), 32'd0);
            if (w_valid) begin
                check($sformatf("t2.c%0d.addr", c), 32'(cfg_addr), 32'(k));
                check($sformatf("t2.c%0d.data", c), 32'(cfg_data), 32'(100 + c));
                k++;
            end
        end
        w_valid = 1'b0;
        step();
        check("t2.done.gs",   32'(global_state), 32'd3);
        check("t2.done.done", 32'(done),         32'd1);
        check("t2.done.cval", 32'(cfg_valid),    32'd0);
        step();

        // Two rounds of x_len=2, mac_len=3 on resident weights
        kick(1'b0, 2, 3, 2);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t3.c%0d.gs", i),   32'(global_state), 32'(exp_gs[i]));
            check($sformatf("t3.c%0d.done", i), 32'(done),         32'(exp_done[i]));
            check($sformatf("t3.c%0d.busy", i), 32'(busy),         32'(exp_busy[i]));
            check($sformatf("t3.c%0d.xph", i),  32'(x_phase),      32'(exp_gs[i] == 1));
            check($sformatf("t3.c%0d.cval", i), 32'(cfg_valid),    32'd0);
            step();
        end

        // Zero lengths clamp to one cycle each
        kick(1'b0, 0, 0, 1);
        check("t4.x.gs",   32'(global_state), 32'd1);
        check("t4.x.cval", 32'(cfg_valid),    32'd0);
        step();
        check("t4.mac.gs", 32'(global_state), 32'd2);
        step();
        check("t4.done.gs",   32'(global_state), 32'd3);
        check("t4.done.done", 32'(done),         32'd1);
        step();

        // start during MAC is ignored
        kick(1'b0, 1, 3, 1);
        check("t5.x.gs", 32'(global_state), 32'd1);
        step();
        check("t5.mac1.gs", 32'(global_state), 32'd2);
        start  = 1'b1;
        load_w = 1'b1;
        step();
        start  = 1'b0;
        check("t5.mac2.gs", 32'(global_state), 32'd2);
        step();
        check("t5.mac3.gs", 32'(global_state), 32'd2);
        step();
        check("t5.done.done", 32'(done), 32'd1);
        step();
        check("t5.idle.gs",   32'(global_state), 32'd3);
        check("t5.idle.wrdy", 32'(w_ready),      32'd0);
        check("t5.idle.busy", 32'(busy),         32'd0);

        // n_iter=0 without weight load goes straight to DONE
        kick(1'b0, 1, 1, 0);
        check("t5b.done.done", 32'(done),         32'd1);
        check("t5b.done.busy", 32'(busy),         32'd0);
        check("t5b.done.gs",   32'(global_state), 32'd3);
        step();
        check("t5b.idle.done", 32'(done), 32'd0);

        // Asynchronous reset mid weight load, then a fresh job restarts at tile 0
        kick(1'b1, 1, 1, 0);
        w_valid = 1'b1;
        w_data  = 8'd77;
        step();
        w_data  = 8'd88;
        step();
        check("t6.pre.addr", 32'(cfg_addr), 32'd1);
        w_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6.async");
        step();
        rst_n = 1'b1;
        kick(1'b1, 1, 1, 0);
        check("t6.re.wrdy", 32'(w_ready), 32'd1);
        w_valid = 1'b1;
        w_data  = 8'd55;
        step();
        w_valid = 1'b0;
        check("t6.re.cval", 32'(cfg_valid), 32'd1);
        check("t6.re.addr", 32'(cfg_addr),  32'd0);
        check("t6.re.data", 32'(cfg_data),  32'd55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
